life_engine: RTL and testbench
==============================

LIFE_ENGINE -- requirements
Module: life_engine

Interface
REQ-001 Parameter ROWS, default 8, meaning grid rows (>=3).
REQ-002 Parameter COLS, default 8, meaning grid columns (>=3).
REQ-003 Parameter WRAP, default 1, meaning 1 = toroidal edges, 0 = cells outside the grid read as dead.
REQ-004 Parameter TICK_DIV, default 1, meaning clock cycles per generation in RUN (>=1).
REQ-005 Parameter GW, default 16, meaning generation counter width.
REQ-006 Port clk  in  1  is the single clock; all state updates on its rising edge.
REQ-007 Port reset_n  in  1  is the reset: asynchronous, active-low.
REQ-008 Port load  in  1  copies seed into the grid.
REQ-009 Port seed  in  ROWS*COLS  is the initial grid; bit r*COLS+c is cell (r,c); 1 = alive.
REQ-010 Port run  in  1  is a level: evolve continuously while high.
REQ-011 Port step  in  1  is a one-cycle pulse: evolve exactly one generation.
REQ-012 Port grid  out  ROWS*COLS  is the current registered grid.
REQ-013 Port gen_count  out  GW  is the generations applied since the last load or reset.
REQ-014 Port state  out  2  is the FSM state encoding.
REQ-015 Ports stable and extinct  out  1 each are the status flags.

Function
REQ-016 Next-state rule per cell, from the 8-neighbour live count n: live with n in {2,3} survives; dead with n==3 is born; every other cell is dead.
REQ-017 Neighbour indices wrap modulo ROWS/COLS when WRAP=1; when WRAP=0, out-of-range neighbours count as 0.
REQ-018 FSM states: IDLE=0, RUN=1, HALT=2; encoding 3 is illegal and returns to IDLE on the next clock.
REQ-019 In any state, load=1 sets grid<=seed, gen_count<=0, stable<=0, extinct<=(seed==0), state<=IDLE; load has priority over run and step.
REQ-020 IDLE: run=1 -> RUN with tick counter cleared; otherwise step=1 -> one generation applied on that edge, and state remains IDLE.
REQ-021 RUN: tick counter counts 0..TICK_DIV-1; a generation is applied on the edge where the counter equals TICK_DIV-1, and the counter then wraps to 0; the first generation lands TICK_DIV cycles after RUN is entered.
REQ-022 RUN: run=0 -> IDLE without applying a generation; the tick counter is cleared; step is ignored in RUN.
REQ-023 Each generation applied sets stable<=(next==grid) and extinct<=(next==0), and increments gen_count, saturating at 2^GW-1.
REQ-024 When a generation applied in RUN leaves stable or extinct at 1 -> HALT.
REQ-025 HALT: grid and gen_count are frozen; run and step are ignored; only load or reset exits HALT.
REQ-026 A step applied in IDLE updates the flags but never enters HALT.
REQ-027 Latency: grid reflects a generation on the edge at which it is applied; there is no output pipeline.

Reset
REQ-028 reset_n=0 immediately, regardless of clk, forces grid=0, gen_count=0, tick counter=0, state=IDLE, stable=0, extinct=1.
REQ-029 Reset asserted mid-RUN abandons the in-flight tick; after release, the block waits in IDLE for load, run or step.

Structure
REQ-030 The shared package life_pkg holds the state typedef (IDLE/RUN/HALT) and the cell-index helper constants.
REQ-031 The per-cell rule lives in sub-module life_cell (inputs: self and 8 neighbours; output: next); it is instantiated ROWS*COLS times by generate loops.
REQ-032 The FSM, tick counter, grid register and flag logic reside in life_engine.

Verification
REQ-033 Blinker, 8x8, WRAP=1, TICK_DIV=1: load a vertical 3-cell bar at col 3, rows 2-4, then pulse step -> horizontal bar at row 3, cols 2-4, gen_count=1; a second step -> original bar, gen_count=2.
REQ-034 Block 2x2 at (3,3), run=1 -> after 1 generation: stable=1, state=HALT, gen_count=1; grid unchanged for 10 more cycles.
REQ-035 Single live cell, run=1 -> extinct=1, HALT, gen_count=1.
REQ-036 Glider, WRAP=1 vs WRAP=0, 32 steps -> WRAP=1 glider reappears shifted by (8,8), i.e. its original position; WRAP=0 grid settles to a 2x2 block in the corner.
REQ-037 TICK_DIV=4, blinker, run=1 for 12 cycles -> gen_count=3, with grid changes only on cycles 4, 8 and 12.
REQ-038 load asserted mid-RUN -> next edge grid=seed, gen_count=0, state=IDLE; reset_n pulsed low between edges -> outputs clear without a clock edge.

Source files
------------

// File: rtl/life_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : life_pkg
//  Description : Shared types and cell-index helpers for the Life engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package life_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam int NBR_COUNT = 8;
    localparam int CNT_W     = 4;

    // Flattened bit position of cell (r,c) in a row-major grid vector.
    function automatic int cell_index(input int r, input int c, input int cols);
        return r * cols + c;
    endfunction

    function automatic int wrap_coord(input int v, input int n);
        if (v < 0) begin
            return v + n;
        end else if (v >= n) begin
            return v - n;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/life_cell.sv
`default_nettype none
// ============================================================================
//  Module      : life_cell
//  Description : Conway rule for one cell from its own state and 8 neighbours.
//  Revision    : 1.0 - initial release
// ============================================================================
module life_cell
    import life_pkg::*;
(
    input  logic                 self,
    input  logic [NBR_COUNT-1:0] nbrs,
    output logic                 next
);

    logic [CNT_W-1:0] w_count;

    always_comb begin
        w_count = '0;
        for (int i = 0; i < NBR_COUNT; i++) begin
            w_count = w_count + {{(CNT_W-1){1'b0}}, nbrs[i]};
        end
        next = (w_count == CNT_W'(3)) || (self && (w_count == CNT_W'(2)));
    end

endmodule
`default_nettype wire

// File: rtl/life_engine.sv
`default_nettype none
// ============================================================================
//  Module      : life_engine
//  Description : Game-of-Life grid with load/step/run control and status flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module life_engine
    import life_pkg::*;
#(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int WRAP     = 1,
    parameter int TICK_DIV = 1,
    parameter int GW       = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic [ROWS*COLS-1:0] seed,
    input  logic                 run,
    input  logic                 step,
    output logic [ROWS*COLS-1:0] grid,
    output logic [GW-1:0]        gen_count,
    output logic [1:0]           state,
    output logic                 stable,
    output logic                 extinct
);

    localparam int          CELLS     = ROWS * COLS;
    localparam int          TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [CELLS-1:0] r_grid;
    logic [GW-1:0]    r_gen;
    logic [1:0]       r_state;
    logic [TW-1:0]    r_tick;
    logic             r_stable;
    logic             r_extinct;

    logic [CELLS-1:0] w_next_grid;
    logic [1:0]       w_state_next;
    logic             w_tick_hit;
    logic             w_step_gen;
    logic             w_run_gen;
    logic             w_next_stable;
    logic             w_next_extinct;

    // ------------------------------------------------------------------
    // Neighbourhood wiring: each cell sees its 8 neighbours, wrapped or
    // tied dead at the border depending on WRAP.
    // ------------------------------------------------------------------
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [NBR_COUNT-1:0] w_nbrs;

            for (genvar k = 0; k < NBR_COUNT; k++) begin : g_nbr
                localparam int DR = (k < 3) ? -1 : ((k < 5) ? 0 : 1);
                localparam int DC = (k == 0 || k == 3 || k == 5) ? -1 :
                                    ((k == 1 || k == 6) ? 0 : 1);
                localparam int NR = r + DR;
                localparam int NC = c + DC;
                localparam bit INSIDE = (NR >= 0) && (NR < ROWS) &&
                                        (NC >= 0) && (NC < COLS);
                if (INSIDE || (WRAP != 0)) begin : g_live
                    assign w_nbrs[k] =
                        r_grid[cell_index(wrap_coord(NR, ROWS), wrap_coord(NC, COLS), COLS)];
                end else begin : g_dead
                    assign w_nbrs[k] = 1'b0;
                end
            end

            life_cell u_cell (
                .self (r_grid[cell_index(r, c, COLS)]),
                .nbrs (w_nbrs),
                .next (w_next_grid[cell_index(r, c, COLS)])
            );
        end
    end

    assign w_next_stable  = (w_next_grid == r_grid);
    assign w_next_extinct = (w_next_grid == '0);

    // ------------------------------------------------------------------
    // FSM: state register / next-state / output decode
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (load) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (run) begin
                        w_state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!run) begin
                        w_state_next = ST_IDLE;
                    end else if (w_run_gen && (w_next_stable || w_next_extinct)) begin
                        w_state_next = ST_HALT;
                    end
                end
                ST_HALT: begin
                    w_state_next = ST_HALT;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // A step in IDLE only counts when run is low, since run=1 takes the RUN path.
    always_comb begin
        w_tick_hit = (r_tick == TICK_LAST);
        w_step_gen = 1'b0;
        w_run_gen  = 1'b0;
        if (!load) begin
            if ((r_state == ST_IDLE) && !run && step) begin
                w_step_gen = 1'b1;
            end
            if ((r_state == ST_RUN) && run && w_tick_hit) begin
                w_run_gen = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Tick divider
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick <= '0;
        end else if (!load && (r_state == ST_RUN) && run) begin
            r_tick <= w_tick_hit ? '0 : (r_tick + 1'b1);
        end else begin
            r_tick <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Grid, generation counter and status flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_grid    <= '0;
            r_gen     <= '0;
            r_stable  <= 1'b0;
            r_extinct <= 1'b1;
        end else if (load) begin
            r_grid    <= seed;
            r_gen     <= '0;
            r_stable  <= 1'b0;
            r_extinct <= (seed == '0);
        end else if (w_step_gen || w_run_gen) begin
            r_grid    <= w_next_grid;
            r_stable  <= w_next_stable;
            r_extinct <= w_next_extinct;
            if (r_gen != '1) begin
                r_gen <= r_gen + 1'b1;
            end
        end
    end

    assign grid      = r_grid;
    assign gen_count = r_gen;
    assign state     = r_state;
    assign stable    = r_stable;
    assign extinct   = r_extinct;

endmodule
`default_nettype wire

// File: tb/tb_life_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_life_engine
//  Description : Scoreboard bench for life_engine (wrap, no-wrap, divided-tick).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_life_engine;

    localparam logic [63:0] VBAR   = (64'd1 << 19) | (64'd1 << 27) | (64'd1 << 35);
    localparam logic [63:0] HBAR   = (64'd1 << 26) | (64'd1 << 27) | (64'd1 << 28);
    localparam logic [63:0] BLOCK  = (64'd1 << 27) | (64'd1 << 28) | (64'd1 << 35) | (64'd1 << 36);
    localparam logic [63:0] SINGLE = (64'd1 << 27);
    localparam logic [63:0] GLIDER = (64'd1 << 1) | (64'd1 << 10) | (64'd1 << 16) |
                                     (64'd1 << 17) | (64'd1 << 18);
    localparam logic [63:0] CORNER = (64'd1 << 54) | (64'd1 << 55) | (64'd1 << 62) | (64'd1 << 63);

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  load_v;
    logic [2:0]  run_v;
    logic [2:0]  step_v;
    logic [63:0] seed_v    [3];
    logic [63:0] grid_v    [3];
    logic [15:0] gen_v     [3];
    logic [1:0]  state_v   [3];
    logic        stable_v  [3];
    logic        extinct_v [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    life_engine #(.ROWS(8), .COLS(8), .WRAP(1), .TICK_DIV(1), .GW(16)) u_wrap (
        .clk(clk), .reset_n(reset_n), .load(load_v[0]), .seed(seed_v[0]),
        .run(run_v[0]), .step(step_v[0]), .grid(grid_v[0]), .gen_count(gen_v[0]),
        .state(state_v[0]), .stable(stable_v[0]), .extinct(extinct_v[0])
    );

    life_engine #(.ROWS(8), .COLS(8), .WRAP(0), .TICK_DIV(1), .GW(16)) u_nowrap (
        .clk(clk), .reset_n(reset_n), .load(load_v[1]), .seed(seed_v[1]),
        .run(run_v[1]), .step(step_v[1]), .grid(grid_v[1]), .gen_count(gen_v[1]),
        .state(state_v[1]), .stable(stable_v[1]), .extinct(extinct_v[1])
    );

    life_engine #(.ROWS(8), .COLS(8), .WRAP(1), .TICK_DIV(4), .GW(16)) u_div4 (
        .clk(clk), .reset_n(reset_n), .load(load_v[2]), .seed(seed_v[2]),
        .run(run_v[2]), .step(step_v[2]), .grid(grid_v[2]), .gen_count(gen_v[2]),
        .state(state_v[2]), .stable(stable_v[2]), .extinct(extinct_v[2])
    );

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    int          c_wrap [3] = '{1, 0, 1};
    int          c_div  [3] = '{1, 1, 4};
    logic [63:0] m_grid    [3];
    int          m_gen     [3];
    logic [1:0]  m_st      [3];
    logic        m_stable  [3];
    logic        m_extinct [3];
    int          m_tick    [3];

    typedef struct {
        int          inst;
        logic [63:0] grid;
        logic [15:0] gen;
        logic [1:0]  st;
        logic        stable;
        logic        extinct;
    } exp_t;

    exp_t sb[$];

    function automatic logic [63:0] life_next(input logic [63:0] g, input int wrap);
        logic [63:0] nx;
        nx = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                int n;
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr;
                        int cc;
                        rr = r + dr;
                        cc = c + dc;
                        if (wrap != 0) begin
                            rr = (rr + 8) % 8;
                            cc = (cc + 8) % 8;
                        end
                        if ((dr != 0 || dc != 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8) begin
                            n += int'(g[rr*8+cc]);
                        end
                    end
                end
                nx[r*8+c] = (n == 3) || (g[r*8+c] && n == 2);
            end
        end
        return nx;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_grid[i] = '0; m_gen[i] = 0; m_st[i] = 2'd0;
            m_stable[i] = 1'b0; m_extinct[i] = 1'b1; m_tick[i] = 0;
        end
    endtask

    task automatic model_gen(input int i, input bit in_run);
        logic [63:0] nx;
        nx = life_next(m_grid[i], c_wrap[i]);
        m_stable[i]  = (nx == m_grid[i]);
        m_extinct[i] = (nx == 64'd0);
        m_grid[i]    = nx;
        if (m_gen[i] < 65535) m_gen[i]++;
        if (in_run && (m_stable[i] || m_extinct[i])) m_st[i] = 2'd2;
    endtask

    task automatic model_clock(input int i);
        if (load_v[i]) begin
            m_grid[i] = seed_v[i]; m_gen[i] = 0; m_stable[i] = 1'b0;
            m_extinct[i] = (seed_v[i] == 64'd0); m_st[i] = 2'd0; m_tick[i] = 0;
        end else begin
            case (m_st[i])
                2'd0: begin
                    if (run_v[i]) begin
                        m_st[i] = 2'd1; m_tick[i] = 0;
                    end else if (step_v[i]) begin
                        model_gen(i, 1'b0);
                    end
                end
                2'd1: begin
                    if (!run_v[i]) begin
                        m_st[i] = 2'd0; m_tick[i] = 0;
                    end else if (m_tick[i] == c_div[i] - 1) begin
                        m_tick[i] = 0;
                        model_gen(i, 1'b1);
                    end else begin
                        m_tick[i]++;
                    end
                end
                2'd2: ;
                default: m_st[i] = 2'd0;
            endcase
        end
    endtask

    // ------------------------------------------------------------------
    // Checking and stimulus helpers
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int i, input logic ld, input logic rn, input logic st,
                         input logic [63:0] sd);
        load_v[i] = ld;
        run_v[i]  = rn;
        step_v[i] = st;
        seed_v[i] = sd;
    endtask

    task automatic tick_cycle();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            model_clock(i);
            e.inst = i; e.grid = m_grid[i]; e.gen = 16'(m_gen[i]); e.st = m_st[i];
            e.stable = m_stable[i]; e.extinct = m_extinct[i];
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("u%0d_grid", e.inst),    grid_v[e.inst],         e.grid);
            check($sformatf("u%0d_gen", e.inst),     64'(gen_v[e.inst]),     64'(e.gen));
            check($sformatf("u%0d_state", e.inst),   64'(state_v[e.inst]),   64'(e.st));
            check($sformatf("u%0d_stable", e.inst),  64'(stable_v[e.inst]),  64'(e.stable));
            check($sformatf("u%0d_extinct", e.inst), 64'(extinct_v[e.inst]), 64'(e.extinct));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] prev;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, 1'b0, 64'd0);
        #1 reset_n = 1'b0;
        #2;
        for (int i = 0; i < 3; i++) begin
            check("rst_grid",    grid_v[i],         64'd0);
            check("rst_gen",     64'(gen_v[i]),     64'd0);
            check("rst_state",   64'(state_v[i]),   64'd0);
            check("rst_stable",  64'(stable_v[i]),  64'd0);
            check("rst_extinct", 64'(extinct_v[i]), 64'd1);
        end
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Blinker by single steps
        drive(0, 1'b1, 1'b0, 1'b0, VBAR); tick_cycle();
        drive(0, 1'b0, 1'b0, 1'b1, VBAR); tick_cycle();
        check("blinker_h", grid_v[0], HBAR);
        check("blinker_gen1", 64'(gen_v[0]), 64'd1);
        drive(0, 1'b0, 1'b0, 1'b0, VBAR); tick_cycle();
        drive(0, 1'b0, 1'b0, 1'b1, VBAR); tick_cycle();
        check("blinker_v", grid_v[0], VBAR);
        check("blinker_gen2", 64'(gen_v[0]), 64'd2);
        drive(0, 1'b0, 1'b0, 1'b0, VBAR); tick_cycle();

        // Still life halts as stable; HALT ignores run and step
        drive(0, 1'b1, 1'b0, 1'b0, BLOCK); tick_cycle();
        drive(0, 1'b0, 1'b1, 1'b0, BLOCK); tick_cycle();
        tick_cycle();
        check("block_stable", 64'(stable_v[0]), 64'd1);
        check("block_halt",   64'(state_v[0]),  64'd2);
        check("block_gen",    64'(gen_v[0]),    64'd1);
        drive(0, 1'b0, 1'b1, 1'b1, BLOCK);
        repeat (10) tick_cycle();
        check("block_frozen",     grid_v[0],        BLOCK);
        check("block_gen_frozen", 64'(gen_v[0]),    64'd1);

        // Lone cell dies and halts as extinct
        drive(0, 1'b1, 1'b0, 1'b0, SINGLE); tick_cycle();
        check("single_loaded_extinct", 64'(extinct_v[0]), 64'd0);
        drive(0, 1'b0, 1'b1, 1'b0, SINGLE); tick_cycle();
        tick_cycle();
        check("single_extinct", 64'(extinct_v[0]), 64'd1);
        check("single_halt",    64'(state_v[0]),   64'd2);
        check("single_gen",     64'(gen_v[0]),     64'd1);
        drive(0, 1'b0, 1'b0, 1'b0, SINGLE); tick_cycle();

        // Glider on torus vs bounded grid, 32 step pulses
        drive(0, 1'b1, 1'b0, 1'b0, GLIDER);
        drive(1, 1'b1, 1'b0, 1'b0, GLIDER);
        tick_cycle();
        for (int s = 0; s < 32; s++) begin
            drive(0, 1'b0, 1'b0, 1'b1, GLIDER);
            drive(1, 1'b0, 1'b0, 1'b1, GLIDER);
            tick_cycle();
            drive(0, 1'b0, 1'b0, 1'b0, GLIDER);
            drive(1, 1'b0, 1'b0, 1'b0, GLIDER);
            tick_cycle();
        end
        check("glider_wrap",     grid_v[0],       GLIDER);
        check("glider_nowrap",   grid_v[1],       CORNER);
        check("glider_gen",      64'(gen_v[1]),   64'd32);
        check("glider_state",    64'(state_v[1]), 64'd0);

        // Divided tick: generations only every 4th cycle in RUN
        drive(2, 1'b1, 1'b0, 1'b0, VBAR); tick_cycle();
        drive(2, 1'b0, 1'b1, 1'b0, VBAR); tick_cycle();
        prev = grid_v[2];
        for (int k = 1; k <= 12; k++) begin
            tick_cycle();
            check($sformatf("div_change_c%0d", k), 64'(grid_v[2] != prev), 64'((k % 4) == 0));
            prev = grid_v[2];
        end
        check("div_gen",  64'(gen_v[2]), 64'd3);
        check("div_grid", grid_v[2],     HBAR);

        // Load wins over run mid-RUN
        drive(2, 1'b1, 1'b1, 1'b0, BLOCK); tick_cycle();
        check("midload_state", 64'(state_v[2]), 64'd0);
        check("midload_gen",   64'(gen_v[2]),   64'd0);
        check("midload_grid",  grid_v[2],       BLOCK);
        drive(2, 1'b0, 1'b1, 1'b0, BLOCK); tick_cycle();
        tick_cycle();

        // Asynchronous reset between edges
        #2 reset_n = 1'b0;
        #1;
        check("areset_grid",    grid_v[2],         64'd0);
        check("areset_gen",     64'(gen_v[2]),     64'd0);
        check("areset_state",   64'(state_v[2]),   64'd0);
        check("areset_extinct", 64'(extinct_v[2]), 64'd1);
        model_reset();
        drive(2, 1'b0, 1'b0, 1'b0, BLOCK);
        #1 reset_n = 1'b1;
        tick_cycle();
        tick_cycle();
        check("post_reset_idle", 64'(state_v[2]), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
